mandel_engine: RTL and testbench

MANDEL_ENGINE -- requirements
Module: mandel_engine

---
 rtl/mandel_pkg.sv | 20 ++
 rtl/mandel_iter_step.sv | 38 +++
 rtl/mandel_engine.sv | 140 ++++++++++++++
 tb/tb_mandel_engine.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mandel_pkg.sv
// Shared constants and types for the Mandelbrot renderer: Q5.13 fixed point
// coordinates, escape threshold and the engine state encoding.
package mandel_pkg;

  localparam int DW        = 18;     // datapath width
  localparam int FRAC      = 13;     // fractional bits
  localparam int ESC_LIMIT = 32768;  // 4.0 in Q5.13

  typedef logic signed [DW-1:0] coord_t;

  typedef enum logic [2:0] {
    StIdle,
    StInit,
    StIter,
    StWrite,
    StNext,
    StDone
  } state_t;

endpackage

// File: rtl/mandel_iter_step.sv
// One combinational z <- z^2 + c step plus the |z|^2 > 4 escape test.
module mandel_iter_step
  import mandel_pkg::*;
(
  input  logic signed [DW-1:0] zr,
  input  logic signed [DW-1:0] zi,
  input  logic signed [DW-1:0] cr,
  input  logic signed [DW-1:0] ci,
  output logic                 escape,
  output logic signed [DW-1:0] zr_next,
  output logic signed [DW-1:0] zi_next
);

  localparam int PW = 2 * DW;

  logic signed [PW-1:0] sq_rr;
  logic signed [PW-1:0] sq_ii;
  logic signed [DW-1:0] zri;
  logic        [DW-1:0] mag_rr;
  logic        [DW-1:0] mag_ii;
  logic        [DW:0]   mag;

  assign sq_rr = (PW'(zr) * PW'(zr)) >>> FRAC;
  assign sq_ii = (PW'(zi) * PW'(zi)) >>> FRAC;
  assign zri   = DW'((PW'(zr) * PW'(zi)) >>> (FRAC - 1));

  // Squares are non-negative; clamp each to 18 bits so a large |z| can never
  // wrap the 19-bit sum back under the threshold.
  assign mag_rr = (|sq_rr[PW-1:DW]) ? '1 : sq_rr[DW-1:0];
  assign mag_ii = (|sq_ii[PW-1:DW]) ? '1 : sq_ii[DW-1:0];
  assign mag    = {1'b0, mag_rr} + {1'b0, mag_ii};
  assign escape = mag > (DW + 1)'(ESC_LIMIT);

  // Only consumed when not escaping, so |z|^2 <= 4 and 18 bits suffice.
  assign zr_next = sq_rr[DW-1:0] - sq_ii[DW-1:0] + cr;
  assign zi_next = zri + ci;

endmodule

// File: rtl/mandel_engine.sv
// Frame renderer: walks every pixel, iterates z^2 + c until escape or the
// iteration cap, and writes the count into the frame buffer.
module mandel_engine
  import mandel_pkg::*;
#(
  parameter int H_RES    = 640,
  parameter int V_RES    = 480,
  parameter int MAX_ITER = 63,
  parameter int X0       = -20480,
  parameter int Y0       = 10752,
  parameter int STEP     = 45
) (
  input  logic        CLK_100MHz,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        wea,
  output logic [18:0] addr_w,
  output logic [6:0]  dina
);

  localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;

  state_t          state;
  logic [XW-1:0]   x;
  logic [YW-1:0]   y;
  logic [6:0]      iter;
  coord_t          cr;
  coord_t          ci;
  coord_t          zr;
  coord_t          zi;
  logic [18:0]     addr;
  logic            escape;
  coord_t          zr_next;
  coord_t          zi_next;
  logic            last_x;
  logic            last_y;

  assign last_x = (x == XW'(H_RES - 1));
  assign last_y = (y == YW'(V_RES - 1));
  assign addr_w = addr;

  mandel_iter_step u_step (
    .zr      (zr),
    .zi      (zi),
    .cr      (cr),
    .ci      (ci),
    .escape  (escape),
    .zr_next (zr_next),
    .zi_next (zi_next)
  );

  // Control FSM, pixel counters and registered write-port outputs.
  always_ff @(posedge CLK_100MHz or negedge reset) begin
    if (!reset) begin
      state <= StIdle;
      busy  <= 1'b0;
      done  <= 1'b0;
      wea   <= 1'b0;
      dina  <= '0;
      addr  <= '0;
      x     <= '0;
      y     <= '0;
      iter  <= '0;
      cr    <= DW'(X0);
      ci    <= DW'(Y0);
      zr    <= '0;
      zi    <= '0;
    end else begin
      wea  <= 1'b0;
      done <= 1'b0;
      unique case (state)
        StIdle: begin
          x    <= '0;
          y    <= '0;
          cr   <= DW'(X0);
          ci   <= DW'(Y0);
          addr <= '0;
          if (start) begin
            busy  <= 1'b1;
            state <= StInit;
          end
        end
        StInit: begin
          zr    <= '0;
          zi    <= '0;
          iter  <= '0;
          state <= StIter;
        end
        StIter: begin
          if (escape) begin
            dina  <= iter;
            wea   <= 1'b1;
            state <= StWrite;
          end else if (iter == 7'(MAX_ITER)) begin
            dina  <= 7'(MAX_ITER);
            wea   <= 1'b1;
            state <= StWrite;
          end else begin
            zr   <= zr_next;
            zi   <= zi_next;
            iter <= iter + 7'd1;
          end
        end
        StWrite: begin
          state <= StNext;
        end
        StNext: begin
          if (last_x && last_y) begin
            done  <= 1'b1;
            state <= StDone;
          end else begin
            if (!last_x) begin
              x  <= x + XW'(1);
              cr <= cr + DW'(STEP);
            end else begin
              x  <= '0;
              cr <= DW'(X0);
              y  <= y + YW'(1);
              ci <= ci - DW'(STEP);
            end
            addr  <= addr + 19'd1;
            state <= StInit;
          end
        end
        StDone: begin
          busy  <= 1'b0;
          state <= StIdle;
        end
        default: begin
          busy  <= 1'b0;
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mandel_engine.sv
// Scoreboard bench: five engine instances (default frame, three 1x1 points,
// a 4x2 frame); expected writes are queued on start, checked on each wea.
module tb_mandel_engine;

  localparam int D_X0 = -20480, D_Y0 = 10752, D_STEP = 45, D_H = 640;
  localparam int S_X0 = -16384, S_Y0 = 4096, S_STEP = 4096, S_H = 4, S_V = 2;

  typedef struct {
    int addr;
    int dina;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        start_v [5];
  wire  [4:0]  busy_v;
  wire  [4:0]  done_v;
  wire  [4:0]  wea_v;
  wire  [18:0] addr_v [5];
  wire  [6:0]  dina_v [5];

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   sel = 0;
  int   done_cnt [5];
  logic wea_prev [5];

  mandel_engine u_def (
    .CLK_100MHz(clk), .reset(rst_n), .start(start_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .wea(wea_v[0]), .addr_w(addr_v[0]), .dina(dina_v[0])
  );
  mandel_engine #(.H_RES(1), .V_RES(1), .X0(0), .Y0(0), .STEP(0)) u_c0 (
    .CLK_100MHz(clk), .reset(rst_n), .start(start_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .wea(wea_v[1]), .addr_w(addr_v[1]), .dina(dina_v[1])
  );
  mandel_engine #(.H_RES(1), .V_RES(1), .X0(8192), .Y0(0), .STEP(0)) u_c1 (
    .CLK_100MHz(clk), .reset(rst_n), .start(start_v[2]), .busy(busy_v[2]), .done(done_v[2]),
    .wea(wea_v[2]), .addr_w(addr_v[2]), .dina(dina_v[2])
  );
  mandel_engine #(.H_RES(1), .V_RES(1), .X0(-8192), .Y0(0), .STEP(0)) u_cm1 (
    .CLK_100MHz(clk), .reset(rst_n), .start(start_v[3]), .busy(busy_v[3]), .done(done_v[3]),
    .wea(wea_v[3]), .addr_w(addr_v[3]), .dina(dina_v[3])
  );
  mandel_engine #(.H_RES(S_H), .V_RES(S_V), .X0(S_X0), .Y0(S_Y0), .STEP(S_STEP)) u_small (
    .CLK_100MHz(clk), .reset(rst_n), .start(start_v[4]), .busy(busy_v[4]), .done(done_v[4]),
    .wea(wea_v[4]), .addr_w(addr_v[4]), .dina(dina_v[4])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input longint got, input longint want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic longint sext18(input longint v);
    logic signed [17:0] t;
    t = v[17:0];
    return longint'(t);
  endfunction

  // Reference escape-time count in wide integer arithmetic.
  function automatic int model_count(input longint cr, input longint ci);
    longint zr = 0, zi = 0, zr2, zi2, zri;
    for (int it = 0; it <= 63; it++) begin
      zr2 = (zr * zr) >>> 13;
      zi2 = (zi * zi) >>> 13;
      zri = (zr * zi) >>> 12;
      if (zr2 + zi2 > 32768) return it;
      if (it == 63) return 63;
      zr = sext18(zr2 - zi2 + cr);
      zi = sext18(zri + ci);
    end
    return 63;
  endfunction

  task automatic push_exp(input int addr, input int dina);
    exp_t e;
    e.addr = addr;
    e.dina = dina;
    exp_q.push_back(e);
  endtask

  // Write monitor: every wea pops one expected write from the scoreboard.
  initial begin
    for (int i = 0; i < 5; i++) begin
      done_cnt[i] = 0;
      wea_prev[i] = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
        if (done_v[i]) done_cnt[i]++;
        if (wea_v[i]) begin
          if (i != sel) begin
            check_eq("stray_wea", longint'(wea_v[i]), 0);
          end else begin
            check_eq("wea_width", longint'(wea_prev[i]), 0);
            check_eq("sb_pending", longint'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
              exp_t e;
              e = exp_q.pop_front();
              check_eq("wr_addr", longint'(addr_v[i]), e.addr);
              check_eq("wr_dina", longint'(dina_v[i]), e.dina);
            end
          end
        end
        wea_prev[i] = wea_v[i];
      end
    end
  end

  // Pulse start on one DUT and watch it until done, stop_writes writes, or budget.
  task automatic run(input int idx, input int budget, input int restart_at, input int stop_writes,
                     output int first_wea, output int done_at);
    int cyc = 0;
    int nw = 0;
    bit hit;
    first_wea = -1;
    done_at = -1;
    sel = idx;
    start_v[idx] = 1'b1;
    while (cyc < budget) begin
      @(posedge clk);
      #1;
      cyc++;
      start_v[idx] = (cyc == restart_at);
      if (cyc == 1) check_eq("busy_rise", longint'(busy_v[idx]), 1);
      if (wea_v[idx]) begin
        nw++;
        if (first_wea < 0) first_wea = cyc;
      end
      if (done_v[idx]) begin
        done_at = cyc;
        break;
      end
      if (stop_writes > 0 && nw >= stop_writes) break;
    end
    start_v[idx] = 1'b0;
    hit = (done_at >= 0) || (stop_writes > 0 && nw >= stop_writes);
    check_eq("run_timeout", longint'(hit), 1);
  endtask

  initial begin
    int fw, da, d0, exp_done, k;
    int lat_tab [3] = '{66, 6, 66};
    int cnt_tab [3] = '{63, 3, 63};
    for (int i = 0; i < 5; i++) start_v[i] = 1'b0;
    rst_n = 1'b0;
    #3;
    check_eq("rst_busy", longint'(busy_v[0]), 0);
    check_eq("rst_done", longint'(done_v[0]), 0);
    check_eq("rst_wea", longint'(wea_v[0]), 0);
    check_eq("rst_addr", longint'(addr_v[0]), 0);
    check_eq("rst_dina", longint'(dina_v[0]), 0);
    #20 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Default frame: first pixel latency, then abort during pixel 10.
    push_exp(0, 1);
    for (int p = 1; p <= 10; p++) push_exp(p, model_count(D_X0 + p * D_STEP, D_Y0));
    run(0, 200, 0, 1, fw, da);
    check_eq("first_wea_cyc", fw, 4);
    run(0, 2000, 0, 9, fw, da);
    repeat (3) @(posedge clk);
    #2;
    d0 = done_cnt[0];
    rst_n = 1'b0;
    #1;
    check_eq("abort_busy", longint'(busy_v[0]), 0);
    check_eq("abort_wea", longint'(wea_v[0]), 0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("abort_addr", longint'(addr_v[0]), 0);
    check_eq("abort_dina", longint'(dina_v[0]), 0);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check_eq("abort_no_done", done_cnt[0] - d0, 0);
    check_eq("abort_left", exp_q.size(), 1);
    exp_q.delete();
    for (int p = 0; p < 3; p++) push_exp(p, model_count(D_X0 + p * D_STEP, D_Y0));
    run(0, 500, 0, 3, fw, da);
    check_eq("rerun_first_wea", fw, 4);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #10 rst_n = 1'b1;
    check_eq("rerun_left", exp_q.size(), 0);
    exp_q.delete();
    @(posedge clk);
    #1;

    // Single-point frames: c = 0, 1.0, -1.0.
    for (int j = 0; j < 3; j++) begin
      d0 = done_cnt[j + 1];
      push_exp(0, cnt_tab[j]);
      run(j + 1, 500, 0, 0, fw, da);
      check_eq("pt_wea_cyc", fw, lat_tab[j]);
      check_eq("pt_done_cyc", da, lat_tab[j] + 2);
      @(posedge clk);
      #1;
      check_eq("pt_done_low", longint'(done_v[j + 1]), 0);
      check_eq("pt_busy_low", longint'(busy_v[j + 1]), 0);
      check_eq("pt_done_cnt", done_cnt[j + 1] - d0, 1);
      check_eq("pt_left", exp_q.size(), 0);
    end

    // 4x2 frame with a start re-pulse mid-frame.
    exp_done = 1;
    for (int yy = 0; yy < S_V; yy++) begin
      for (int xx = 0; xx < S_H; xx++) begin
        k = model_count(S_X0 + xx * S_STEP, S_Y0 - yy * S_STEP);
        push_exp(yy * S_H + xx, k);
        exp_done += k + 4;
      end
    end
    d0 = done_cnt[4];
    run(4, 3000, 40, 0, fw, da);
    check_eq("small_first_wea", fw, 4);
    check_eq("small_done_cyc", da, exp_done);
    repeat (30) @(posedge clk);
    #1;
    check_eq("small_busy_low", longint'(busy_v[4]), 0);
    check_eq("small_done_cnt", done_cnt[4] - d0, 1);
    check_eq("small_left", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", n_err);
    $fatal(1);
  end

endmodule
